// File: rtl/mfft_pkg.sv
// Shared definitions for the mixed-radix FFT combine stage: scheduler FSM
// state encoding and the twiddle index width.
package mfft_pkg;

  localparam int PHI_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mfft_sched_delay.sv
// Valid/index delay line matching the twiddle multiplier latency.
// Shifts only on advancing cycles so a downstream stall freezes every item
// in place. 'pending' reports items still inside the multiplier, i.e. in
// any stage except the last one (which emerges at the next advance).
module mfft_sched_delay #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             pending
);

  localparam logic [DEPTH-1:0] LOW_MASK = DEPTH'((64'd1 << (DEPTH - 1)) - 64'd1);

  logic [DEPTH-1:0] valid_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  // Shift register of (valid, index) pairs, frozen while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else if (advance) begin
      valid_q[0] <= in_valid;
      idx_q[0]   <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];
  assign pending   = |(valid_q & LOW_MASK);

endmodule

// File: rtl/mfft_combine_scheduler.sv
// Combine-stage scheduler: reads the odd sub-FFT into the twiddle
// multiplier, then reads the matching even sample when the product
// emerges, and flags the summer outputs k / k+NFFT/2.
// Optional build macro: MFFT_SCHED_PROTOCOL_CHECK_EN adds a sticky
// err_protocol output.
// Handshake: an edge with out_ready high is an "advancing" edge; only
// advancing edges move the schedule. On a non-advancing edge state,
// counters, phi and the delay line hold and all strobes drop to 0.
module mfft_combine_scheduler
  import mfft_pkg::*;
#(
  parameter int SIZE_BUFFER  = 3,
  parameter int MULT_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flag_complete_chet,
  input  logic                   flag_complete_Nchet,
  input  logic                   out_ready,
  output logic                   resiveFromNChet,
  output logic                   resiveFromChet,
  output logic                   enMult,
  output logic [PHI_WIDTH-1:0]   phi,
  output logic                   out_valid,
  output logic [SIZE_BUFFER-1:0] counterMultData2,
  output logic                   frame_done,
  output logic                   busy
`ifdef MFFT_SCHED_PROTOCOL_CHECK_EN
  ,
  output logic                   err_protocol
`endif
);

  localparam logic [SIZE_BUFFER-1:0] K_LAST =
    SIZE_BUFFER'((1 << (SIZE_BUFFER - 1)) - 1);

  sched_state_e           state_q, state_d;
  logic [SIZE_BUFFER-1:0] k_q, k_d;
  logic                   issue;
  logic                   frame_end;
  logic                   dl_valid, dl_pending;
  logic [SIZE_BUFFER-1:0] dl_idx;
  logic                   sum_v;
  logic [SIZE_BUFFER-1:0] sum_idx;

  mfft_sched_delay #(
    .DEPTH (MULT_LATENCY),
    .IDX_W (SIZE_BUFFER)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .advance   (out_ready),
    .in_valid  (issue),
    .in_idx    (k_q),
    .out_valid (dl_valid),
    .out_idx   (dl_idx),
    .pending   (dl_pending)
  );

  // State and odd-read counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next state: the transition out of IDLE already issues odd sample 0.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    issue     = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (out_ready && (state_q == ST_RUN ||
                          (flag_complete_chet && flag_complete_Nchet))) begin
          issue   = 1'b1;
          state_d = ST_RUN;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_FLUSH;
          end else begin
            k_d = k_q + SIZE_BUFFER'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (out_ready && sum_v && sum_idx == K_LAST) begin
          frame_end = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Summer stage: one cycle after the even read of a sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_v   <= 1'b0;
      sum_idx <= '0;
    end else if (out_ready) begin
      sum_v   <= dl_valid;
      sum_idx <= dl_idx;
    end
  end

  // Registered outputs; strobes drop on stalled cycles, phi/index hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resiveFromNChet  <= 1'b0;
      resiveFromChet   <= 1'b0;
      enMult           <= 1'b0;
      phi              <= '0;
      out_valid        <= 1'b0;
      counterMultData2 <= '0;
      frame_done       <= 1'b0;
      busy             <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      if (out_ready) begin
        resiveFromNChet <= issue;
        enMult          <= issue | dl_pending;
        resiveFromChet  <= dl_valid;
        out_valid       <= sum_v;
        frame_done      <= frame_end;
        if (issue)                   phi <= PHI_WIDTH'(k_q);
        else if (state_d == ST_IDLE) phi <= '0;
        if (sum_v) counterMultData2 <= sum_idx;
      end else begin
        resiveFromNChet <= 1'b0;
        enMult          <= 1'b0;
        resiveFromChet  <= 1'b0;
        out_valid       <= 1'b0;
        frame_done      <= 1'b0;
      end
    end
  end

`ifdef MFFT_SCHED_PROTOCOL_CHECK_EN
  localparam int STALL_W = SIZE_BUFFER + 2;
  localparam logic [STALL_W-1:0] NFFT = STALL_W'(1 << SIZE_BUFFER);

  logic               flag_c_q, flag_n_q;
  logic [STALL_W-1:0] stall_cnt;

  // Sticky protocol error: a ready flag falling mid-frame, or the
  // downstream stalling the flush for more than NFFT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_c_q     <= 1'b0;
      flag_n_q     <= 1'b0;
      stall_cnt    <= '0;
      err_protocol <= 1'b0;
    end else begin
      flag_c_q <= flag_complete_chet;
      flag_n_q <= flag_complete_Nchet;
      if (state_q == ST_FLUSH && !out_ready) begin
        if (stall_cnt <= NFFT) stall_cnt <= stall_cnt + STALL_W'(1);
      end else begin
        stall_cnt <= '0;
      end
      if ((state_q != ST_IDLE &&
           ((flag_c_q && !flag_complete_chet) ||
            (flag_n_q && !flag_complete_Nchet))) ||
          stall_cnt > NFFT)
        err_protocol <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mfft_combine_scheduler.sv
// Directed bench for mfft_combine_scheduler (SIZE_BUFFER=3, MULT_LATENCY=3).
// Cycle t0 is the cycle whose closing edge sees both flags and out_ready
// high; masks below use bit i for cycle t0+i, sampled mid-cycle.
// Define MFFT_SCHED_PROTOCOL_CHECK_EN to also exercise err_protocol.
module tb_mfft_combine_scheduler;

  localparam int SB = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flag_c = 1'b0;
  logic          flag_n = 1'b0;
  logic          out_ready = 1'b0;
  logic          resiveFromNChet, resiveFromChet, enMult;
  logic [15:0]   phi;
  logic          out_valid;
  logic [SB-1:0] counterMultData2;
  logic          frame_done, busy;
`ifdef MFFT_SCHED_PROTOCOL_CHECK_EN
  logic          err_protocol;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0]   m_odd, m_chet, m_en, m_ov, m_fd, m_busy;
  logic [15:0]   phi_at [32];
  logic [SB-1:0] idx_at [32];

  mfft_combine_scheduler #(
    .SIZE_BUFFER  (SB),
    .MULT_LATENCY (3)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .flag_complete_chet  (flag_c),
    .flag_complete_Nchet (flag_n),
    .out_ready           (out_ready),
    .resiveFromNChet     (resiveFromNChet),
    .resiveFromChet      (resiveFromChet),
    .enMult              (enMult),
    .phi                 (phi),
    .out_valid           (out_valid),
    .counterMultData2    (counterMultData2),
    .frame_done          (frame_done),
    .busy                (busy)
`ifdef MFFT_SCHED_PROTOCOL_CHECK_EN
    ,
    .err_protocol        (err_protocol)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Idle with flags low for n cycles.
  task automatic idle(input int n);
    flag_c = 1'b0;
    flag_n = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Raise both flags with out_ready in the current cycle (this is t0).
  task automatic start_frame;
    @(negedge clk);
    flag_c = 1'b1;
    flag_n = 1'b1;
    out_ready = 1'b1;
  endtask

  // Capture n cycles after t0; optional out_ready stall and flag drop.
  task automatic trace(input int n, input int stall_at, input int stall_len,
                       input int drop_at);
    m_odd = '0; m_chet = '0; m_en = '0; m_ov = '0; m_fd = '0; m_busy = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      m_odd[i]  = resiveFromNChet;
      m_chet[i] = resiveFromChet;
      m_en[i]   = enMult;
      m_ov[i]   = out_valid;
      m_fd[i]   = frame_done;
      m_busy[i] = busy;
      phi_at[i] = phi;
      idx_at[i] = counterMultData2;
      if (i == stall_at) out_ready = 1'b0;
      if (i == stall_at + stall_len) out_ready = 1'b1;
      if (i == drop_at) begin
        flag_c = 1'b0;
        flag_n = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({resiveFromNChet, resiveFromChet, enMult, phi, out_valid,
         counterMultData2, frame_done, busy} !== '0) begin
      $display("FAIL reset_outputs: got nch=%b ch=%b en=%b phi=%0d ov=%b idx=%0d fd=%b busy=%b, want all 0",
               resiveFromNChet, resiveFromChet, enMult, phi, out_valid,
               counterMultData2, frame_done, busy);
      bad++;
    end
    reset = 1'b1;
    idle(2);
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle_busy: got %b want 0", busy); bad++;
    end
  endtask

  task automatic test_basic_frame;
    idle(2);
    start_frame();
    trace(12, 0, 0, 1);
    total++;
    if (m_odd !== 32'h0000_001E) begin
      $display("FAIL basic_odd: got %h want 0000001e", m_odd); bad++;
    end
    total++;
    if (m_chet !== 32'h0000_00F0) begin
      $display("FAIL basic_chet: got %h want 000000f0", m_chet); bad++;
    end
    total++;
    if (m_ov !== 32'h0000_01E0) begin
      $display("FAIL basic_out_valid: got %h want 000001e0", m_ov); bad++;
    end
    total++;
    if (m_fd !== 32'h0000_0100) begin
      $display("FAIL basic_frame_done: got %h want 00000100", m_fd); bad++;
    end
    total++;
    if (m_en !== 32'h0000_007E) begin
      $display("FAIL basic_enmult: got %h want 0000007e", m_en); bad++;
    end
    total++;
    if (m_busy !== 32'h0000_00FE) begin
      $display("FAIL basic_busy: got %h want 000000fe", m_busy); bad++;
    end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (phi_at[i] !== 16'(i - 1)) begin
        $display("FAIL basic_phi[%0d]: got %0d want %0d", i, phi_at[i], i - 1); bad++;
      end
      total++;
      if (idx_at[i+4] !== SB'(i - 1)) begin
        $display("FAIL basic_index[%0d]: got %0d want %0d", i + 4, idx_at[i+4], i - 1); bad++;
      end
    end
    total++;
    if (phi_at[9] !== 16'd0) begin
      $display("FAIL basic_phi_idle: got %0d want 0", phi_at[9]); bad++;
    end
  endtask

  task automatic test_stall;
    idle(2);
    start_frame();
    trace(14, 2, 2, 1);
    total++;
    if (m_odd !== 32'h0000_0066) begin
      $display("FAIL stall_odd: got %h want 00000066", m_odd); bad++;
    end
    total++;
    if (m_chet !== 32'h0000_03C0) begin
      $display("FAIL stall_chet: got %h want 000003c0", m_chet); bad++;
    end
    total++;
    if (m_ov !== 32'h0000_0780) begin
      $display("FAIL stall_out_valid: got %h want 00000780", m_ov); bad++;
    end
    total++;
    if (m_fd !== 32'h0000_0400) begin
      $display("FAIL stall_frame_done: got %h want 00000400", m_fd); bad++;
    end
    total++;
    if (m_en !== 32'h0000_01E6) begin
      $display("FAIL stall_enmult: got %h want 000001e6", m_en); bad++;
    end
    total++;
    if (m_busy !== 32'h0000_03FE) begin
      $display("FAIL stall_busy: got %h want 000003fe", m_busy); bad++;
    end
    total++;
    if (phi_at[3] !== 16'd1 || phi_at[4] !== 16'd1 ||
        phi_at[5] !== 16'd2 || phi_at[6] !== 16'd3) begin
      $display("FAIL stall_phi: got %0d %0d %0d %0d want 1 1 2 3",
               phi_at[3], phi_at[4], phi_at[5], phi_at[6]); bad++;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (idx_at[7+i] !== SB'(i)) begin
        $display("FAIL stall_index[%0d]: got %0d want %0d", 7 + i, idx_at[7+i], i); bad++;
      end
    end
  endtask

  task automatic test_flag_gate;
    logic any_strobe, any_busy;
    idle(2);
    flag_n = 1'b1;
    any_strobe = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_strobe |= resiveFromNChet | resiveFromChet | enMult | out_valid;
      any_busy |= busy;
    end
    total++;
    if (any_strobe !== 1'b0) begin
      $display("FAIL gate_no_strobe: got %b want 0", any_strobe); bad++;
    end
    total++;
    if (any_busy !== 1'b0) begin
      $display("FAIL gate_busy: got %b want 0", any_busy); bad++;
    end
    flag_c = 1'b1;
    trace(12, 0, 0, 1);
    total++;
    if (m_odd !== 32'h0000_001E) begin
      $display("FAIL gate_start_odd: got %h want 0000001e", m_odd); bad++;
    end
  endtask

  task automatic test_reset_mid;
    idle(2);
    start_frame();
    for (int i = 1; i <= 7; i++) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || counterMultData2 !== SB'(2)) begin
      $display("FAIL mid_third_valid: got ov=%b idx=%0d want ov=1 idx=2",
               out_valid, counterMultData2); bad++;
    end
    reset = 1'b0;
    #1;
    total++;
    if ({resiveFromNChet, resiveFromChet, enMult, phi, out_valid,
         counterMultData2, frame_done, busy} !== '0) begin
      $display("FAIL mid_async_clear: got nch=%b ch=%b en=%b phi=%0d ov=%b idx=%0d fd=%b busy=%b, want all 0",
               resiveFromNChet, resiveFromChet, enMult, phi, out_valid,
               counterMultData2, frame_done, busy);
      bad++;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    trace(12, 0, 0, 1);
    total++;
    if (m_odd !== 32'h0000_001E) begin
      $display("FAIL mid_restart_odd: got %h want 0000001e", m_odd); bad++;
    end
    total++;
    if (phi_at[1] !== 16'd0 || phi_at[4] !== 16'd3) begin
      $display("FAIL mid_restart_phi: got %0d..%0d want 0..3", phi_at[1], phi_at[4]); bad++;
    end
    total++;
    if (m_fd !== 32'h0000_0100) begin
      $display("FAIL mid_restart_done: got %h want 00000100", m_fd); bad++;
    end
  endtask

  task automatic test_back_to_back;
    idle(2);
    start_frame();
    trace(20, 0, 0, 10);
    total++;
    if (m_odd !== 32'h0000_1E1E) begin
      $display("FAIL b2b_odd: got %h want 00001e1e", m_odd); bad++;
    end
    total++;
    if (m_fd !== 32'h0001_0100) begin
      $display("FAIL b2b_frame_done: got %h want 00010100", m_fd); bad++;
    end
    total++;
    if (m_ov !== 32'h0001_E1E0) begin
      $display("FAIL b2b_out_valid: got %h want 0001e1e0", m_ov); bad++;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (phi_at[9+i] !== 16'(i)) begin
        $display("FAIL b2b_phi[%0d]: got %0d want %0d", 9 + i, phi_at[9+i], i); bad++;
      end
    end
  endtask

`ifdef MFFT_SCHED_PROTOCOL_CHECK_EN
  task automatic test_protocol;
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
    total++;
    if (err_protocol !== 1'b0) begin
      $display("FAIL proto_clear: got %b want 0", err_protocol); bad++;
    end
    start_frame();
    trace(12, 0, 0, 2);
    total++;
    if (m_fd !== 32'h0000_0100) begin
      $display("FAIL proto_frame_done: got %h want 00000100", m_fd); bad++;
    end
    total++;
    if (err_protocol !== 1'b1) begin
      $display("FAIL proto_set: got %b want 1", err_protocol); bad++;
    end
    idle(10);
    total++;
    if (err_protocol !== 1'b1) begin
      $display("FAIL proto_sticky: got %b want 1", err_protocol); bad++;
    end
    reset = 1'b0;
    #1;
    total++;
    if (err_protocol !== 1'b0) begin
      $display("FAIL proto_reset: got %b want 0", err_protocol); bad++;
    end
    reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_flag_gate();
    test_reset_mid();
    test_back_to_back();
`ifdef MFFT_SCHED_PROTOCOL_CHECK_EN
    test_protocol();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
